syn_array_seq: RTL and testbench

Control sequencer that drives the synapse array's per-cycle control: configuration word, row/column enables, read strobes, retime/write enable and data-memory read/write addresses. It runs a small program of step words stored in an internal program memory, loaded by the host, and replays it on `start`. It is the issuing end of the control interface that every synapse tile consumes. One instance sits beside the array and fans out to all tiles.

---
 rtl/syn_array_seq.sv | 147 ++++++++++++++
 tb/tb_syn_array_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/syn_array_seq.sv
// Synapse-array control sequencer: replays a host-loaded program of step words onto the tile control bus.
// Optional multi-pass replay is enabled by defining SYN_SEQ_LOOP_EN (adds i_loop_cnt).
module syn_array_seq #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int ADDR_DMEM = 8,
    parameter int PROG_AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_prog_we,
    input  logic [PROG_AW-1:0]   i_prog_waddr,
    input  logic [31:0]          i_prog_wdata,
    input  logic                 i_start,
    input  logic [ROWS-1:0]      i_row_mask,
    input  logic [COLS-1:0]      i_clm_mask,
    input  logic [ADDR_DMEM-1:0] i_r_base,
    input  logic [ADDR_DMEM-1:0] i_w_base,
`ifdef SYN_SEQ_LOOP_EN
    input  logic [7:0]           i_loop_cnt,
`endif
    output logic [15:0]          o_cfgdat,
    output logic [ROWS-1:0]      o_row_en,
    output logic [COLS-1:0]      o_clm_en,
    output logic                 o_row_rd,
    output logic                 o_clm_rd,
    output logic                 o_rtm_en,
    output logic [ADDR_DMEM-1:0] o_r_addr,
    output logic [ADDR_DMEM-1:0] o_w_addr,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

    localparam logic [PROG_AW-1:0] PC_LAST = '1;

    state_t                 r_state, w_state_nxt;
    logic [PROG_AW-1:0]     r_pc;
    // Reserved bits [1:0] are never stored: word bit n lives at storage bit n-2.
    logic [29:0]            r_mem [2**PROG_AW];
    logic [29:0]            r_word;
    logic [7:0]             r_cnt;
    logic [ROWS-1:0]        r_row_mask;
    logic [COLS-1:0]        r_clm_mask;
    logic [ADDR_DMEM-1:0]   r_raddr;
    logic [ADDR_DMEM-1:0]   r_waddr;
    logic [29:0]            w_rd_word;
    logic                   w_accept;
    logic                   w_step_end;
    logic                   w_pass_end;
    logic                   w_more_pass;
    logic                   w_unused_rsvd;

    assign w_unused_rsvd = ^i_prog_wdata[1:0];
    assign w_rd_word     = r_mem[r_pc];
    assign w_accept      = (r_state == S_IDLE) && i_start;
    assign w_step_end    = (r_state == S_RUN) && (r_cnt == 8'd0);
    assign w_pass_end    = r_word[2] || (r_pc == PC_LAST);

`ifdef SYN_SEQ_LOOP_EN
    logic [7:0] r_loop;
    assign w_more_pass = (r_loop != 8'd0);

    always_ff @(posedge clk) begin
        if (rst)
            r_loop <= 8'd0;
        else if (w_accept)
            r_loop <= i_loop_cnt;
        else if (w_step_end && w_pass_end && w_more_pass)
            r_loop <= r_loop - 8'd1;
    end
`else
    assign w_more_pass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_prog_we && (r_state == S_IDLE))
            r_mem[i_prog_waddr] <= i_prog_wdata[31:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_word     <= '0;
            r_cnt      <= 8'd0;
            r_row_mask <= '0;
            r_clm_mask <= '0;
            r_raddr    <= '0;
            r_waddr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pc       <= '0;
                r_row_mask <= i_row_mask;
                r_clm_mask <= i_clm_mask;
                r_raddr    <= i_r_base;
                r_waddr    <= i_w_base;
            end else if (w_step_end) begin
                r_pc <= w_pass_end ? '0 : r_pc + PROG_AW'(1);
            end
            if (r_state == S_FETCH) begin
                r_word <= w_rd_word;
                r_cnt  <= w_rd_word[13:6];
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 8'd1;
                if (r_word[1])
                    r_raddr <= r_raddr + ADDR_DMEM'(1);
                if (r_word[0])
                    r_waddr <= r_waddr + ADDR_DMEM'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_cfgdat    = '0;
        o_row_en    = '0;
        o_clm_en    = '0;
        o_row_rd    = 1'b0;
        o_clm_rd    = 1'b0;
        o_rtm_en    = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_RUN;
            S_RUN: begin
                o_cfgdat = r_word[29:14];
                o_row_en = r_row_mask;
                o_clm_en = r_clm_mask;
                o_row_rd = r_word[5];
                o_clm_rd = r_word[4];
                o_rtm_en = r_word[3];
                if (w_step_end)
                    w_state_nxt = (w_pass_end && !w_more_pass) ? S_DONE : S_FETCH;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_r_addr = r_raddr;
    assign o_w_addr = r_waddr;
    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_syn_array_seq.sv
// Directed bench for syn_array_seq: per-cycle vector tables plus hand-written multi-cycle sequences.
module tb_syn_array_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_prog_we;
    logic [3:0]  i_prog_waddr;
    logic [31:0] i_prog_wdata;
    logic        i_start;
    logic [7:0]  i_row_mask, i_clm_mask, i_r_base, i_w_base;
`ifdef SYN_SEQ_LOOP_EN
    logic [7:0]  i_loop_cnt;
`endif
    logic [15:0] o_cfgdat;
    logic [7:0]  o_row_en, o_clm_en, o_r_addr, o_w_addr;
    logic        o_row_rd, o_clm_rd, o_rtm_en, o_busy, o_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    syn_array_seq dut (
        .clk(clk), .rst(rst),
        .i_prog_we(i_prog_we), .i_prog_waddr(i_prog_waddr), .i_prog_wdata(i_prog_wdata),
        .i_start(i_start), .i_row_mask(i_row_mask), .i_clm_mask(i_clm_mask),
        .i_r_base(i_r_base), .i_w_base(i_w_base),
`ifdef SYN_SEQ_LOOP_EN
        .i_loop_cnt(i_loop_cnt),
`endif
        .o_cfgdat(o_cfgdat), .o_row_en(o_row_en), .o_clm_en(o_clm_en),
        .o_row_rd(o_row_rd), .o_clm_rd(o_clm_rd), .o_rtm_en(o_rtm_en),
        .o_r_addr(o_r_addr), .o_w_addr(o_w_addr), .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct {
        logic        start;
        logic [52:0] exp;
    } vec_t;

    vec_t q[$];

    function automatic logic [52:0] ebus(logic [15:0] cfg, logic [7:0] re, logic [7:0] ce,
                                         logic rr, logic cr, logic rt,
                                         logic [7:0] ra, logic [7:0] wa, logic b, logic d);
        return {cfg, re, ce, rr, cr, rt, ra, wa, b, d};
    endfunction

    function automatic logic [52:0] out_bus();
        return {o_cfgdat, o_row_en, o_clm_en, o_row_rd, o_clm_rd, o_rtm_en,
                o_r_addr, o_w_addr, o_busy, o_done};
    endfunction

    function automatic logic [31:0] mkw(logic [15:0] cfg, logic [7:0] rep, logic rr, logic cr,
                                        logic rt, logic la, logic ri, logic wi);
        return {cfg, rep, rr, cr, rt, la, ri, wi, 2'b00};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_prog_we = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1; i_start = 1'b0; i_prog_we = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic load(int a, logic [31:0] d);
        i_prog_we = 1'b1; i_prog_waddr = 4'(a); i_prog_wdata = d;
        tick();
    endtask

    task automatic push(logic st, logic [52:0] e);
        vec_t v;
        v.start = st; v.exp = e;
        q.push_back(v);
    endtask

    task automatic run_q(string nm);
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("%s[%0d]", nm, i), {11'b0, out_bus()}, {11'b0, q[i].exp});
            i_start = q[i].start;
            tick();
            i_start = 1'b0;
        end
        q.delete();
    endtask

    initial begin
        logic seen;
        rst = 1'b1; i_prog_we = 1'b0; i_prog_waddr = '0; i_prog_wdata = '0; i_start = 1'b0;
        i_row_mask = '0; i_clm_mask = '0; i_r_base = '0; i_w_base = '0;
`ifdef SYN_SEQ_LOOP_EN
        i_loop_cnt = '0;
`endif

        // Reset, then a run over whatever the program memory holds must still finish.
        do_rst();
        chk("reset_outputs", {11'b0, out_bus()}, 64'd0);
        i_start = 1'b1; tick(); i_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5000 && !seen; k++) begin
            if (o_done) seen = 1'b1;
            else tick();
        end
        chk("empty_run_done", {63'b0, seen}, 64'd1);

        // Single step, rep=3, write address stepping.
        do_rst();
        load(0, mkw(16'h8A5C, 8'd3, 0, 0, 1, 1, 0, 1));
        i_row_mask = 8'h0F; i_clm_mask = 8'hF0; i_r_base = 8'h20; i_w_base = 8'h10;
        push(1, ebus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h20, 8'h10, 1, 0));
        for (int k = 0; k < 4; k++)
            push(0, ebus(16'h8A5C, 8'h0F, 8'hF0, 0, 0, 1, 8'h20, 8'h10 + 8'(k), 1, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h20, 8'h14, 1, 1));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h20, 8'h14, 0, 0));
        run_q("single");

        // Three single-cycle steps, last on word 2; word 3 must never be reached.
        do_rst();
        load(0, mkw(16'h1111, 0, 1, 0, 0, 0, 0, 0));
        load(1, mkw(16'h2222, 0, 0, 1, 0, 0, 0, 0));
        load(2, mkw(16'h3333, 0, 0, 0, 1, 1, 0, 0));
        load(3, mkw(16'h4444, 0, 1, 1, 1, 1, 1, 1));
        i_row_mask = 8'hFF; i_clm_mask = 8'h81; i_r_base = 8'h00; i_w_base = 8'h00;
        push(1, ebus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        push(0, ebus(16'h1111, 8'hFF, 8'h81, 1, 0, 0, 0, 0, 1, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        push(0, ebus(16'h2222, 8'hFF, 8'h81, 0, 1, 0, 0, 0, 1, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        push(0, ebus(16'h3333, 8'hFF, 8'h81, 0, 0, 1, 0, 0, 1, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        push(0, ebus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_q("multi");

        // Read address wraps through FF -> 00.
        do_rst();
        load(0, mkw(16'h0001, 8'd3, 0, 0, 0, 1, 1, 0));
        i_row_mask = 8'h01; i_clm_mask = 8'h02; i_r_base = 8'hFE; i_w_base = 8'h05;
        push(1, ebus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'hFE, 8'h05, 1, 0));
        push(0, ebus(16'h0001, 8'h01, 8'h02, 0, 0, 0, 8'hFE, 8'h05, 1, 0));
        push(0, ebus(16'h0001, 8'h01, 8'h02, 0, 0, 0, 8'hFF, 8'h05, 1, 0));
        push(0, ebus(16'h0001, 8'h01, 8'h02, 0, 0, 0, 8'h00, 8'h05, 1, 0));
        push(0, ebus(16'h0001, 8'h01, 8'h02, 0, 0, 0, 8'h01, 8'h05, 1, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h02, 8'h05, 1, 1));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h02, 8'h05, 0, 0));
        run_q("wrap");

        // Full 16-word program without last; start/prog_we while busy are ignored.
        do_rst();
        for (int k = 0; k < 16; k++)
            load(k, mkw(16'(k), 0, 0, 0, 0, 0, 1, 0));
        i_row_mask = 8'h3C; i_clm_mask = 8'hC3; i_r_base = 8'h00; i_w_base = 8'h00;
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            logic [52:0] e;
            if (c == 34)
                e = ebus(0, 0, 0, 0, 0, 0, 8'h10, 0, 0, 0);
            else if (c == 33)
                e = ebus(0, 0, 0, 0, 0, 0, 8'h10, 0, 1, 1);
            else if (c % 2 == 1)
                e = ebus(0, 0, 0, 0, 0, 0, 8'((c - 1) / 2), 0, 1, 0);
            else
                e = ebus(16'((c - 2) / 2), 8'h3C, 8'hC3, 0, 0, 0, 8'((c - 2) / 2), 0, 1, 0);
            chk($sformatf("prog_end[%0d]", c), {11'b0, out_bus()}, {11'b0, e});
            if (c == 3) begin
                i_prog_we = 1'b1; i_prog_waddr = 4'd5;
                i_prog_wdata = mkw(16'hBEEF, 0, 1, 1, 1, 1, 0, 0);
            end
            i_start = (c == 4) || (c == 20);
            @(posedge clk); #1;
            if (c != 3) i_prog_we = 1'b0;
            i_start = 1'b0;
        end

        // Write and start in the same idle cycle: FETCH sees the new word.
        i_prog_we = 1'b1; i_prog_waddr = 4'd0;
        i_prog_wdata = mkw(16'hCAFE, 0, 1, 1, 1, 1, 0, 0);
        i_r_base = 8'h77;
        push(1, ebus(0, 0, 0, 0, 0, 0, 8'h10, 0, 0, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h77, 0, 1, 0));
        push(0, ebus(16'hCAFE, 8'h3C, 8'hC3, 1, 1, 1, 8'h77, 0, 1, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h77, 0, 1, 1));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h77, 0, 0, 0));
        run_q("wr_start");

        // Reset in the middle of a long step abandons the run.
        do_rst();
        load(0, mkw(16'h5555, 8'd10, 0, 0, 1, 1, 0, 1));
        i_row_mask = 8'hAA; i_clm_mask = 8'h55; i_r_base = 8'h00; i_w_base = 8'h40;
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick(); tick();
        chk("rst_mid_run", {11'b0, out_bus()},
            {11'b0, ebus(16'h5555, 8'hAA, 8'h55, 0, 0, 1, 0, 8'h41, 1, 0)});
        rst = 1'b1; tick();
        chk("rst_mid_clear", {11'b0, out_bus()}, 64'd0);
        rst = 1'b0; tick();
        chk("rst_mid_idle", {11'b0, out_bus()}, 64'd0);

`ifdef SYN_SEQ_LOOP_EN
        // Two passes over one word; addresses carry on, one done pulse.
        do_rst();
        load(0, mkw(16'h00C3, 8'd1, 0, 0, 0, 1, 1, 0));
        i_row_mask = 8'hFF; i_clm_mask = 8'hFF; i_r_base = 8'h00; i_w_base = 8'h00;
        i_loop_cnt = 8'd1;
        push(1, ebus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0));
        push(0, ebus(16'h00C3, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 0, 1, 0));
        push(0, ebus(16'h00C3, 8'hFF, 8'hFF, 0, 0, 0, 8'h01, 0, 1, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h02, 0, 1, 0));
        push(0, ebus(16'h00C3, 8'hFF, 8'hFF, 0, 0, 0, 8'h02, 0, 1, 0));
        push(0, ebus(16'h00C3, 8'hFF, 8'hFF, 0, 0, 0, 8'h03, 0, 1, 0));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h04, 0, 1, 1));
        push(0, ebus(0, 0, 0, 0, 0, 0, 8'h04, 0, 0, 0));
        run_q("loop");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
